irq_encoder: RTL and testbench

Registered 32-to-5 priority encoder with request latching and a valid/ack handshake; the inverse of the 5-to-32 register-select decoder. It collects 32 one-bit request lines (interrupt/exception causes), holds them as pending, and presents the index of the highest-priority unmasked pending request to the MIPS control unit. The index stays stable until the consumer acknowledges it. Lowest index has the highest priority.

---
 rtl/irq_encoder_pkg.sv | 22 ++
 rtl/prio_enc32.sv | 25 ++
 rtl/irq_encoder.sv | 84 ++++++++
 tb/tb_irq_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/irq_encoder_pkg.sv
// rtl/irq_encoder_pkg.sv - shared constants and types for the irq_encoder slice
//
// Contents:
//   N, W     : number of request lines and code width
//   req_vec_t: one bit per request line
//   code_t   : encoded request index
//   state_t  : selection FSM states
package irq_encoder_pkg;

  localparam int N = 32;
  localparam int W = 5;

  typedef logic [N-1:0] req_vec_t;
  typedef logic [W-1:0] code_t;

  // The FSM state is exactly the valid flag. EMPTY is 0 and HOLD is 1.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc32.sv
// rtl/prio_enc32.sv - combinational 32-bit lowest-index-first priority encoder
//
// Ports:
//   elig : input  [31:0] candidate vector
//   idx  : output [4:0]  index of the lowest set bit (0 when elig is zero)
//   any  : output        1 when elig has any bit set
module prio_enc32
  import irq_encoder_pkg::*;
(
  input  req_vec_t elig,
  output code_t    idx,
  output logic     any
);

  // Scan from the top down so the lowest set index is the last write and wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) idx = code_t'(i);
    end
  end

  assign any = |elig;

endmodule

// File: rtl/irq_encoder.sv
// rtl/irq_encoder.sv - registered 32-to-5 priority encoder with request latching and valid/ack
//
// Ports:
//   clk     : input         rising-edge clock
//   rst     : input         synchronous active-high reset
//   req     : input  [31:0] request strobes, latched into pending
//   mask    : input  [31:0] 1 = line may be selected; masked lines still latch
//   ack     : input         consumer accepts code (ignored while valid = 0)
//   valid   : output        code holds a pending index
//   code    : output [4:0]  selected index, bit 0 highest priority
//   pending : output [31:0] latched request bits
module irq_encoder
  import irq_encoder_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req,
  input  req_vec_t mask,
  input  logic     ack,
  output logic     valid,
  output code_t    code,
  output req_vec_t pending
);

  state_t   state;
  logic     consume;
  req_vec_t clr;
  req_vec_t elig;
  code_t    next_idx;
  logic     next_any;

  // The line being acknowledged this cycle is cleared from pending and also
  // excluded from the next selection, so the same request is never delivered
  // twice from one latch event.
  assign consume = (state == HOLD) && ack;
  assign clr     = consume ? (req_vec_t'(1) << code) : '0;
  assign elig    = pending & mask & ~clr;

  prio_enc32 u_prio (
    .elig (elig),
    .idx  (next_idx),
    .any  (next_any)
  );

  // A request arriving on the line being cleared wins: the OR comes last.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | req;
    end
  end

  // Selection FSM. In HOLD without ack nothing changes, even if a higher
  // priority request arrives or the held line becomes masked.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      code  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (next_any) begin
            code  <= next_idx;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            if (next_any) begin
              code <= next_idx;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign valid = (state == HOLD);

endmodule

// File: tb/tb_irq_encoder.sv
// tb/tb_irq_encoder.sv - scoreboard testbench for irq_encoder
module tb_irq_encoder;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic [31:0] mask;
  logic        ack;
  logic        valid;
  logic [4:0]  code;
  logic [31:0] pending;

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];

  irq_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .valid   (valid),
    .code    (code),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: a new presentation is a valid cycle following either an idle
  // cycle or an accepted code. Each one pops one expected index.
  logic prev_valid = 1'b0;
  logic prev_ack   = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && (!prev_valid || prev_ack)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_code: got %0d expected none", code);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(code) != e) begin
            errors++;
            $display("FAIL code_seq: got %0d expected %0d", code, e);
          end
        end
      end
      prev_valid = (valid === 1'b1) && !rst;
      prev_ack   = ack;
    end
  end

  initial begin
    rst  = 1'b1;
    req  = 32'hFFFF_FFFF;
    mask = 32'hFFFF_FFFF;
    ack  = 1'b0;

    // Reset and idle
    step();
    step();
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_code", {27'b0, code}, 32'd0);
    rst = 1'b0;
    req = 32'h0;
    step();
    step();
    check("idle_valid", {31'b0, valid}, 32'd0);
    check("idle_pending", pending, 32'd0);

    // Single request latency
    req = 32'h0000_0100;
    exp_q.push_back(8);
    step();
    req = 32'h0;
    check("lat_pending", pending, 32'h0000_0100);
    check("lat_valid_early", {31'b0, valid}, 32'd0);
    step();
    check("lat_valid", {31'b0, valid}, 32'd1);
    check("lat_code", {27'b0, code}, 32'd8);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_valid", {31'b0, valid}, 32'd0);
    check("ack_pending", pending, 32'd0);

    // Priority and hold
    req = 32'h0010_0020;
    exp_q.push_back(5);
    step();
    req = 32'h0000_0004;
    step();
    req = 32'h0;
    check("prio_code", {27'b0, code}, 32'd5);
    check("prio_pending", pending, 32'h0010_0024);
    step();
    check("hold_code", {27'b0, code}, 32'd5);
    check("hold_valid", {31'b0, valid}, 32'd1);
    exp_q.push_back(2);
    exp_q.push_back(20);
    ack = 1'b1;
    step();
    check("b2b_code2", {27'b0, code}, 32'd2);
    check("b2b_valid2", {31'b0, valid}, 32'd1);
    step();
    check("b2b_code20", {27'b0, code}, 32'd20);
    check("b2b_valid20", {31'b0, valid}, 32'd1);
    step();
    ack = 1'b0;
    check("b2b_empty", {31'b0, valid}, 32'd0);
    check("b2b_pending", pending, 32'd0);

    // Mask
    mask = 32'hFFFF_FFFE;
    req  = 32'h8000_0001;
    exp_q.push_back(31);
    step();
    req = 32'h0;
    step();
    check("mask_code", {27'b0, code}, 32'd31);
    check("mask_pending", pending, 32'h8000_0001);
    exp_q.push_back(0);
    ack  = 1'b1;
    mask = 32'hFFFF_FFFF;
    step();
    ack = 1'b0;
    check("unmask_code", {27'b0, code}, 32'd0);
    check("unmask_valid", {31'b0, valid}, 32'd1);
    check("unmask_pending", pending, 32'h0000_0001);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("unmask_done", {31'b0, valid}, 32'd0);

    // Set-wins collision
    req = 32'h0000_0008;
    exp_q.push_back(3);
    step();
    req = 32'h0;
    step();
    check("col_code", {27'b0, code}, 32'd3);
    exp_q.push_back(3);
    ack = 1'b1;
    req = 32'h0000_0008;
    step();
    ack = 1'b0;
    req = 32'h0;
    check("col_pending", pending, 32'h0000_0008);
    step();
    check("col_valid", {31'b0, valid}, 32'd1);
    check("col_code_again", {27'b0, code}, 32'd3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("col_clear", pending, 32'd0);

    // Reset mid-operation
    req = 32'h0000_00F0;
    exp_q.push_back(4);
    step();
    req = 32'h0;
    step();
    check("mid_code", {27'b0, code}, 32'd4);
    check("mid_valid", {31'b0, valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_pending", pending, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("post_rst_valid", {31'b0, valid}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
